alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Arbitrates one 32-bit ALU among NREQ requesters (CGRA processing elements or the core's execute stage) using per-requester valid/ready handshakes. Each accepted request is computed by the shared ALU in the grant cycle. The result, zero flag and requester ID are captured in a single output register stage. That stage is drained through a valid/ready response port, so back-to-back traffic sustains one operation per cycle.

## Interface
- NREQ, 4: number of requesters, 1..16.
- IDW, derived as max(1, clog2(NREQ)): width of the requester ID.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  bit i set: requester i presents an operation.
- req_ready_o  out  NREQ  one-hot (or zero); bit i set: requester i is accepted this cycle.
- req_op_i  in  3*NREQ  ALU opcode of requester i at bits [3i+2:3i].
- req_a_i  in  32*NREQ  operand A of requester i at bits [32i+31:32i].
- req_b_i  in  32*NREQ  operand B of requester i at bits [32i+31:32i].
- rsp_valid_o  out  1  response register holds a result.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_data_o  out  32  result.
- rsp_zero_o  out  1  set when operand A equals operand B (equality compare, not result==0).
- rsp_id_o  out  IDW  index of the requester that produced the response.

## Operation
- Opcodes:
  - SUM=001: a+b.
  - SUB=010: a-b.
  - AND=011.
  - OR=100.
  - XOR=101.
  - MUL=110: low 32 bits of a*b.
  - 000 and 111: pass a through unchanged.
- All arithmetic is unsigned, modulo 2^32. Overflow is not flagged.
- accept = !rsp_valid_o || rsp_ready_i. The output register can load in the same cycle it is drained.
- Round-robin pointer ptr, range 0..NREQ-1, reset to 0.
  - The winner is the first i with req_valid_i[i] set, searching ptr, ptr+1, … with wrap at NREQ.
  - grant = one-hot of the winner, or zero if no request is valid.
- req_ready_o = grant & {NREQ{accept}}. When accept=0, every req_ready_o bit is 0.
- Handshake completes on req_valid_i[i] && req_ready_o[i]. On the next edge:
  - the winner's operands go through the ALU and load rsp_data_o / rsp_zero_o;
  - rsp_id_o = i;
  - rsp_valid_o = 1;
  - ptr = (i+1) mod NREQ.
- Response drained (rsp_ready_i=1) with no new grant: rsp_valid_o goes to 0. Data, zero and ID hold their last values.
- No grant (no valid request, or accept=0): ptr holds.
- req_ready_o depends combinationally on req_valid_i and rsp_ready_i. Requesters must not derive req_valid_i from req_ready_o.
- A requester holds its valid, opcode and operands stable until accepted. The block samples them only in the accept cycle.
- NREQ=1: ptr is constantly 0 and rsp_id_o is 0.

## Timing
- Reset values: rsp_valid_o=0, rsp_data_o=0, rsp_zero_o=0, rsp_id_o=0, ptr=0. req_ready_o=0 while rst_n_i is low.
- Latency: a request accepted in cycle N is visible on rsp_* in cycle N+1.
- Throughput: 1 per cycle while rsp_ready_i=1.
- Stall: rsp_valid_o=1 with rsp_ready_i=0 holds all rsp_* outputs stable and forces req_ready_o=0.
- Reset asserted mid-operation: the pending response is discarded, with no handshake. Requesters re-present after reset.
- The ALU sits combinationally between the winner mux and the response register. The MUL path sets the critical path.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest valid index always wins and ptr is not implemented.
  - Undefined (default): round-robin as described above.
- Response timing and all other behaviour are identical in both modes.

## Structure
- Shared package holds:
  - the opcode constants SUM, SUB, AND, OR, XOR, MUL;
  - the 32-bit data width constant;
  - the IDW derivation function.
- Sub-module rr_arbiter: takes req vector, ptr and accept; produces grant one-hot, winner index and next ptr. It contains the fixed-priority variant under ALU_ARB_FIXED_PRIO_EN.
- The ALU is instantiated once. Operand and opcode muxing is done by winner index in this block.

## Test plan
- Reset, single request: req0 SUM a=5, b=7, rsp_ready_i=1. Expect rsp_valid_o in the next cycle, data=12, zero=0, id=0.
- Round-robin, NREQ=4: all four valid continuously with distinct XOR ops, rsp_ready_i=1. Expect grant order 0,1,2,3,0 on consecutive cycles and one response per cycle.
- Backpressure: rsp_ready_i=0 for 3 cycles after a response. Expect rsp_* stable, req_ready_o=0. On release, the next response appears one cycle later with no loss or duplication.
- Arithmetic edges:
  - SUB 0-1 → 0xFFFFFFFF;
  - MUL 0x10000×0x10000 → 0;
  - op 111 with a=0xDEADBEEF → 0xDEADBEEF;
  - a=b=3 → zero=1.
- Reset mid-traffic: assert rst_n_i low while rsp_valid_o=1 and requests are pending. Expect rsp_valid_o=0 immediately, and on release grants restart from index 0.
- Fixed priority (ALU_ARB_FIXED_PRIO_EN defined): req0 and req2 held valid. Expect req0 granted every cycle and req2 never granted.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_pkg
// Purpose  : Shared definitions for the shared-ALU arbitration block:
//            ALU opcode encodings, datapath width and the requester-ID
//            width derivation.
// Revision : 1.0 - initial release
// ============================================================================
package alu_share_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;

   // Opcodes 000 and 111 both pass operand A through unchanged.
   typedef enum logic [OP_W-1:0] {
      OP_PASS0 = 3'b000,
      OP_SUM   = 3'b001,
      OP_SUB   = 3'b010,
      OP_AND   = 3'b011,
      OP_OR    = 3'b100,
      OP_XOR   = 3'b101,
      OP_MUL   = 3'b110,
      OP_PASS7 = 3'b111
   } alu_op_e;

   // Requester-ID width: at least one bit even for a single requester.
   function automatic int idw_f(input int nreq);
      return (nreq <= 1) ? 1 : $clog2(nreq);
   endfunction

endpackage : alu_share_ctrl_pkg
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_if
// Purpose  : Request/response bundle of the shared-ALU block.
//            master : requesters + response consumer
//            slave  : alu_share_ctrl
// Signals  : req_valid_i/req_ready_o  per-requester handshake (NREQ bits)
//            req_op_i/req_a_i/req_b_i packed per-requester operation
//            rsp_valid_o/rsp_ready_i  response handshake
//            rsp_data_o/rsp_zero_o/rsp_id_o response payload
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if
   import alu_share_ctrl_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int IDW = idw_f(NREQ);

   logic [NREQ-1:0]        req_valid_i;
   logic [NREQ-1:0]        req_ready_o;
   logic [OP_W*NREQ-1:0]   req_op_i;
   logic [DATA_W*NREQ-1:0] req_a_i;
   logic [DATA_W*NREQ-1:0] req_b_i;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i;
   logic [DATA_W-1:0]      rsp_data_o;
   logic                   rsp_zero_o;
   logic [IDW-1:0]         rsp_id_o;

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_id_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_id_o
   );

endinterface : alu_share_ctrl_if
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_rr_arbiter
// Purpose  : Request arbiter for the shared ALU. Round-robin by default,
//            starting the search at i_ptr; fixed lowest-index priority when
//            ALU_ARB_FIXED_PRIO_EN is defined (i_ptr then ignored).
// Ports    : i_req      request vector
//            i_ptr      round-robin start index
//            i_accept   response stage can load this cycle
//            o_grant    one-hot grant, gated by i_accept
//            o_winner   index of the selected requester (ungated)
//            o_fire     a grant is issued this cycle
//            o_ptr_nxt  pointer value for the next cycle
// Config   : ALU_ARB_FIXED_PRIO_EN
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl_rr_arbiter
   import alu_share_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = idw_f(NREQ)
) (
   input  wire logic [NREQ-1:0] i_req,
   input  wire logic [IDW-1:0]  i_ptr,
   input  wire logic            i_accept,
   output logic      [NREQ-1:0] o_grant,
   output logic      [IDW-1:0]  o_winner,
   output logic                 o_fire,
   output logic      [IDW-1:0]  o_ptr_nxt
);

   logic            w_found;
   int              w_sel;
   logic [NREQ-1:0] w_grant_raw;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      w_found = 1'b0;
      w_sel   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && i_req[k]) begin
            w_found = 1'b1;
            w_sel   = k;
         end
      end
   end

   assign o_ptr_nxt = '0;
`else
   logic [NREQ-1:0] w_rot;

   always_comb begin
      // Rotate so bit k of w_rot is requester (ptr+k) mod NREQ; the first
      // set bit is then the round-robin winner.
      w_rot   = NREQ'({i_req, i_req} >> i_ptr);
      w_found = 1'b0;
      w_sel   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sel   = int'(i_ptr) + k;
         end
      end
      if (w_sel >= NREQ) begin
         w_sel = w_sel - NREQ;
      end
   end

   always_comb begin
      o_ptr_nxt = i_ptr;
      if (o_fire) begin
         o_ptr_nxt = (int'(o_winner) == NREQ - 1) ? '0 : o_winner + 1'b1;
      end
   end
`endif

   always_comb begin
      w_grant_raw = '0;
      for (int j = 0; j < NREQ; j++) begin
         w_grant_raw[j] = w_found && (w_sel == j);
      end
   end

   assign o_winner = IDW'(w_sel);
   assign o_fire   = w_found & i_accept;
   assign o_grant  = w_grant_raw & {NREQ{i_accept}};

endmodule : alu_share_ctrl_rr_arbiter
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Shares one 32-bit ALU among NREQ requesters. One requester is
//            granted per cycle, its operation is computed combinationally in
//            the grant cycle and captured in a single response register that
//            is drained through a valid/ready port (1 op/cycle sustained).
// Ports    : clk_i    clock
//            rst_n_i  asynchronous active-low reset
//            bus      alu_share_ctrl_if.slave (request + response bundle)
// Config   : ALU_ARB_FIXED_PRIO_EN - fixed lowest-index priority instead of
//            round-robin; no pointer register in that build.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  wire logic          clk_i,
   input  wire logic          rst_n_i,
   alu_share_ctrl_if.slave    bus
);

   localparam int IDW = idw_f(NREQ);

   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_zero;
   logic [IDW-1:0]    r_rsp_id;

   logic              w_accept;
   logic [NREQ-1:0]   w_grant;
   logic [IDW-1:0]    w_winner;
   logic              w_fire;
   logic [IDW-1:0]    w_ptr;
   logic [IDW-1:0]    w_ptr_nxt;

   logic [OP_W-1:0]   w_op;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_eq;

   // The response register can take a new result when empty or being
   // drained this cycle. Gated by reset so no request is acknowledged
   // while rst_n_i is low.
   assign w_accept = rst_n_i & (~r_rsp_valid | bus.rsp_ready_i);

   // ------------------------------------------------------------------
   // Arbitration pointer
   // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused_ptr_nxt;
   assign w_unused_ptr_nxt = ^w_ptr_nxt;
   assign w_ptr            = '0;
`else
   logic [IDW-1:0] r_ptr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end

   assign w_ptr = r_ptr;
`endif

   alu_share_ctrl_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req     (bus.req_valid_i),
      .i_ptr     (w_ptr),
      .i_accept  (w_accept),
      .o_grant   (w_grant),
      .o_winner  (w_winner),
      .o_fire    (w_fire),
      .o_ptr_nxt (w_ptr_nxt)
   );

   assign bus.req_ready_o = w_grant;

   // ------------------------------------------------------------------
   // Operand / opcode mux by winner index
   // ------------------------------------------------------------------
   always_comb begin
      w_op = '0;
      w_a  = '0;
      w_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_op = bus.req_op_i[OP_W*i +: OP_W];
            w_a  = bus.req_a_i[DATA_W*i +: DATA_W];
            w_b  = bus.req_b_i[DATA_W*i +: DATA_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // Shared ALU (single instance). Unsigned, modulo 2^32; MUL keeps the
   // low word only. The zero flag is an operand equality compare.
   // ------------------------------------------------------------------
   always_comb begin
      w_alu_res = w_a;
      case (w_op)
         OP_SUM:  w_alu_res = w_a + w_b;
         OP_SUB:  w_alu_res = w_a - w_b;
         OP_AND:  w_alu_res = w_a & w_b;
         OP_OR:   w_alu_res = w_a | w_b;
         OP_XOR:  w_alu_res = w_a ^ w_b;
         OP_MUL:  w_alu_res = w_a * w_b;
         default: w_alu_res = w_a;
      endcase
   end

   assign w_eq = (w_a == w_b);

   // ------------------------------------------------------------------
   // Response register: loads on grant, clears valid on drain without a
   // new grant; payload holds its last value when idle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_zero  <= 1'b0;
         r_rsp_id    <= '0;
      end else begin
         if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_alu_res;
            r_rsp_zero  <= w_eq;
            r_rsp_id    <= w_winner;
         end else if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_data_o  = r_rsp_data;
   assign bus.rsp_zero_o  = r_rsp_zero;
   assign bus.rsp_id_o    = r_rsp_id;

endmodule : alu_share_ctrl
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Directed self-checking bench for alu_share_ctrl (NREQ=4,
//            round-robin build) with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;
   import alu_share_ctrl_pkg::*;

   localparam int NREQ = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   alu_share_ctrl_if #(.NREQ(NREQ)) bus ();

   alu_share_ctrl #(.NREQ(NREQ)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        z;
      logic [1:0]  id;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          auto_clear = 1'b1;

   logic [2:0]  op_q [NREQ];
   logic [31:0] a_q  [NREQ];
   logic [31:0] b_q  [NREQ];

   always_comb begin
      bus.req_op_i = '0;
      bus.req_a_i  = '0;
      bus.req_b_i  = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_op_i[3*i +: 3]  = op_q[i];
         bus.req_a_i[32*i +: 32] = a_q[i];
         bus.req_b_i[32*i +: 32] = b_q[i];
      end
   end

   function automatic logic [31:0] model(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         3'b001:  return a + b;
         3'b010:  return a - b;
         3'b011:  return a & b;
         3'b100:  return a | b;
         3'b101:  return a ^ b;
         3'b110:  return 32'(64'(a) * 64'(b));
         default: return a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      op_q[i] = op;
      a_q[i]  = a;
      b_q[i]  = b;
      bus.req_valid_i[i] = 1'b1;
   endtask

   // Falling edge: pop and compare a response being handed over.
   task automatic neg();
      exp_t e;
      @(negedge clk);
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(bus.rsp_valid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_data", bus.rsp_data_o, e.d);
            chk("sb_zero", 32'(bus.rsp_zero_o), 32'(e.z));
            chk("sb_id",   32'(bus.rsp_id_o), 32'(e.id));
         end
      end
   endtask

   // Push expectations for accepted requests, advance past the rising edge.
   task automatic pos();
      logic [NREQ-1:0] acc;
      exp_t e;
      acc = bus.req_valid_i & bus.req_ready_o;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            e.d  = model(op_q[i], a_q[i], b_q[i]);
            e.z  = (a_q[i] == b_q[i]);
            e.id = 2'(i);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (auto_clear) bus.req_valid_i = bus.req_valid_i & ~acc;
   endtask

   task automatic tick();
      neg();
      pos();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  rr_ord [5];
      int          e_idx  [6];
      logic [2:0]  e_op   [6];
      logic [31:0] e_a    [6];
      logic [31:0] e_b    [6];
      logic [31:0] e_d    [6];
      logic        e_z    [6];

      rr_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      e_idx = '{3, 0, 1, 2, 3, 0};
      e_op  = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b011, 3'b000};
      e_a   = '{32'd0, 32'h0001_0000, 32'hDEAD_BEEF, 32'd3, 32'hF0F0_F0F0, 32'hCAFE_F00D};
      e_b   = '{32'd1, 32'h0001_0000, 32'h1234_5678, 32'd3, 32'hFF00_FF00, 32'd0};
      e_d   = '{32'hFFFF_FFFF, 32'd0, 32'hDEAD_BEEF, 32'd6, 32'hF000_F000, 32'hCAFE_F00D};
      e_z   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < NREQ; i++) begin
         op_q[i] = '0;
         a_q[i]  = '0;
         b_q[i]  = '0;
      end
      bus.rsp_ready_i = 1'b1;

      // ---- reset state, requests present during reset ----
      bus.req_valid_i = 4'hF;
      @(negedge clk);
      chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_data",  bus.rsp_data_o, 32'd0);
      chk("rst_zero",  32'(bus.rsp_zero_o), 32'd0);
      chk("rst_id",    32'(bus.rsp_id_o), 32'd0);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      bus.req_valid_i = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---- round-robin: all four valid continuously ----
      auto_clear = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'b101, 32'hA5A5_0000 | 32'(i), 32'h0F0F_F0F0 << i);
      end
      for (int k = 0; k < 5; k++) begin
         neg();
         chk("rr_grant", 32'(bus.req_ready_o), 32'(rr_ord[k]));
         if (k > 0) chk("rr_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
         pos();
      end
      bus.req_valid_i = '0;
      tick();
      auto_clear = 1'b1;

      // ---- single request: req0 SUM 5+7 ----
      set_req(0, 3'b001, 32'd5, 32'd7);
      neg();
      chk("single_grant", 32'(bus.req_ready_o), 32'b0001);
      pos();
      neg();
      chk("single_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("single_data",  bus.rsp_data_o, 32'd12);
      chk("single_zero",  32'(bus.rsp_zero_o), 32'd0);
      chk("single_id",    32'(bus.rsp_id_o), 32'd0);
      pos();

      // ---- backpressure: 3 stalled cycles ----
      set_req(1, 3'b010, 32'd100, 32'd30);
      set_req(2, 3'b100, 32'h0000_00F0, 32'h0000_000F);
      neg();
      chk("bp_grant", 32'(bus.req_ready_o), 32'b0010);
      pos();
      bus.rsp_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         neg();
         chk("bp_valid", 32'(bus.rsp_valid_o), 32'd1);
         chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
         chk("bp_data",  bus.rsp_data_o, 32'd70);
         chk("bp_id",    32'(bus.rsp_id_o), 32'd1);
         pos();
      end
      bus.rsp_ready_i = 1'b1;
      neg();
      chk("bp_rel_grant", 32'(bus.req_ready_o), 32'b0100);
      pos();
      neg();
      chk("bp_next_data", bus.rsp_data_o, 32'h0000_00FF);
      pos();

      // ---- arithmetic edges, back to back ----
      for (int e = 0; e < 6; e++) begin
         set_req(e_idx[e], e_op[e], e_a[e], e_b[e]);
         neg();
         if (e > 0) begin
            chk("edge_data", bus.rsp_data_o, e_d[e-1]);
            chk("edge_zero", 32'(bus.rsp_zero_o), 32'(e_z[e-1]));
         end
         pos();
      end
      neg();
      chk("edge_data", bus.rsp_data_o, e_d[5]);
      chk("edge_zero", 32'(bus.rsp_zero_o), 32'(e_z[5]));
      pos();

      // ---- reset mid-traffic ----
      auto_clear = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'b001, 32'(i), 32'd10);
      end
      tick();
      bus.rsp_ready_i = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("mr_ready", 32'(bus.req_ready_o), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.rsp_ready_i = 1'b1;
      neg();
      chk("mr_grant0", 32'(bus.req_ready_o), 32'b0001);
      pos();
      neg();
      chk("mr_grant1", 32'(bus.req_ready_o), 32'b0010);
      pos();
      bus.req_valid_i = '0;
      tick();
      tick();
      chk("idle_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("sb_empty",   32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_share_ctrl
`default_nettype wire
